// File: rtl/frame_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | frame_scheduler: paces engine generations to VGA frames and           |
// | arbitrates the field memory between display and engine.  Rev 1.0      |
// +-----------------------------------------------------------------------+
module frame_scheduler #(
  parameter int ADDR_W  = 13,
  parameter int GEN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run_en,
  input  logic              i_step,
  input  logic              i_clr_ovr,
  input  logic              i_draw_active,
  input  logic              i_v_sync,
  input  logic [ADDR_W-1:0] i_disp_addr,
  input  logic              i_eng_req,
  input  logic              i_eng_we,
  input  logic [ADDR_W-1:0] i_eng_addr,
  input  logic              i_eng_wdata,
  input  logic              i_eng_done,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic              o_mem_wdata,
  output logic              o_eng_gnt,
  output logic              o_eng_start,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [15:0]       o_gen_cnt
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_run  = 1'b1;
  localparam logic [7:0] c_last    = 8'(GEN_DIV - 1);

  logic [0:0]  state_q, state_d;
  logic        vs_q, vs_d;
  logic        arm_q, arm_d;
  logic        evt_q, evt_d;
  logic [7:0]  frm_cnt_q, frm_cnt_d;
  logic        step_pend_q, step_pend_d;
  logic        ovr_q, ovr_d;
  logic [15:0] gen_cnt_q, gen_cnt_d;
  logic        start_q, start_d;
  logic        w_go;

  // A generation launches on a frame event when the divider is due or a step waits.
  assign w_go = evt_q & (((frm_cnt_q == c_last) & i_run_en) | step_pend_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: if (w_go)       state_d = c_st_run;
      c_st_run:  if (i_eng_done) state_d = c_st_idle;
      default:                   state_d = c_st_idle;
    endcase
  end

  always_comb begin
    o_busy      = (state_q == c_st_run);
    o_eng_start = start_q;
    o_overrun   = ovr_q;
    o_gen_cnt   = gen_cnt_q;
    o_mem_addr  = i_disp_addr;
    o_mem_we    = 1'b0;
    o_mem_wdata = 1'b0;
    o_eng_gnt   = 1'b0;
    if (!i_draw_active && (state_q == c_st_run) && i_eng_req) begin
      o_eng_gnt   = 1'b1;
      o_mem_addr  = i_eng_addr;
      o_mem_we    = i_eng_we;
      o_mem_wdata = i_eng_wdata;
    end
  end

  always_comb begin
    // arm_q blocks a spurious edge when v_sync is already low out of reset.
    vs_d        = i_v_sync;
    arm_d       = arm_q | i_v_sync;
    evt_d       = vs_q & ~i_v_sync & arm_q;
    frm_cnt_d   = frm_cnt_q;
    step_pend_d = step_pend_q;
    start_d     = 1'b0;
    ovr_d       = (ovr_q & ~i_clr_ovr) | ((state_q == c_st_run) & evt_q);
    gen_cnt_d   = gen_cnt_q;
    if (state_q == c_st_idle) begin
      start_d = w_go;
      if (w_go) begin
        step_pend_d = 1'b0;
      end else if (i_step) begin
        step_pend_d = 1'b1;
      end
      if (!i_run_en || w_go) begin
        frm_cnt_d = 8'd0;
      end else if (evt_q) begin
        frm_cnt_d = frm_cnt_q + 8'd1;
      end
    end else begin
      frm_cnt_d = 8'd0;
      if (i_eng_done) begin
        gen_cnt_d = gen_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b1;
      arm_q       <= 1'b0;
      evt_q       <= 1'b0;
      frm_cnt_q   <= 8'd0;
      step_pend_q <= 1'b0;
      ovr_q       <= 1'b0;
      gen_cnt_q   <= 16'd0;
      start_q     <= 1'b0;
    end else begin
      vs_q        <= vs_d;
      arm_q       <= arm_d;
      evt_q       <= evt_d;
      frm_cnt_q   <= frm_cnt_d;
      step_pend_q <= step_pend_d;
      ovr_q       <= ovr_d;
      gen_cnt_q   <= gen_cnt_d;
      start_q     <= start_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter ADDR_W, default 13, SHALL set the field memory address width.
REQ-002 Parameter GEN_DIV, default 4, SHALL set the number of frames per generation, legal range 1..255.
REQ-003 clk  in  1  system/pixel clock; all state SHALL be updated on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 i_run_en  in  1  free-run enable for automatic generations.
REQ-006 i_step  in  1  single-cycle pulse requesting one generation.
REQ-007 i_clr_ovr  in  1  clears the overrun flag.
REQ-008 i_draw_active  in  1  VGA active-area indicator.
REQ-009 i_v_sync  in  1  VGA vertical sync, active-low.
REQ-010 i_disp_addr  in  ADDR_W  display read address.
REQ-011 i_eng_req  in  1  engine memory access request.
REQ-012 i_eng_we  in  1  engine write enable, qualified by i_eng_req.
REQ-013 i_eng_addr  in  ADDR_W  engine address.
REQ-014 i_eng_wdata  in  1  engine write data (one cell).
REQ-015 i_eng_done  in  1  single-cycle pulse: engine finished the generation.
REQ-016 o_mem_addr  out  ADDR_W  field memory address.
REQ-017 o_mem_we  out  1  field memory write enable.
REQ-018 o_mem_wdata  out  1  field memory write data.
REQ-019 o_eng_gnt  out  1  engine access granted this cycle.
REQ-020 o_eng_start  out  1  single-cycle pulse starting a generation.
REQ-021 o_busy  out  1  high while in RUN.
REQ-022 o_overrun  out  1  sticky overrun flag.
REQ-023 o_gen_cnt  out  16  completed generation count.

Function
REQ-024 Frame event SHALL be the cycle after i_v_sync is sampled 1 then 0 (registered falling edge); i_v_sync low at reset release SHALL NOT produce an event.
REQ-025 FSM states SHALL be IDLE and RUN; reset state IDLE.
REQ-026 IDLE: each frame event SHALL increment an 8-bit frame counter; at event with counter == GEN_DIV-1 and i_run_en=1, counter SHALL reset to 0.
REQ-027 An i_step pulse in IDLE SHALL set a step-pending flag; i_step in RUN SHALL be ignored.
REQ-028 IDLE -> RUN SHALL occur on a frame event when (counter == GEN_DIV-1 and i_run_en) or step-pending; o_eng_start SHALL pulse exactly one cycle, on the transition cycle; step-pending SHALL clear; counter SHALL be 0.
REQ-029 i_run_en=0 SHALL hold the frame counter at 0.
REQ-030 RUN -> IDLE SHALL occur the cycle after i_eng_done; o_gen_cnt SHALL increment by 1, wrapping 0xFFFF -> 0.
REQ-031 Frame counter SHALL hold 0 in RUN; a frame event in RUN SHALL set o_overrun, which SHALL remain set until i_clr_ovr; simultaneous set and clear SHALL leave it set.
REQ-032 i_eng_done in the same cycle as a frame event SHALL complete the generation and SHALL set o_overrun.
REQ-033 Memory mux SHALL be combinational: i_draw_active=1 -> o_mem_addr=i_disp_addr, o_mem_we=0, o_eng_gnt=0, regardless of state.
REQ-034 i_draw_active=0, state RUN, i_eng_req=1 -> o_eng_gnt=1, o_mem_addr=i_eng_addr, o_mem_we=i_eng_we, o_mem_wdata=i_eng_wdata.
REQ-035 All other cases -> o_mem_addr=i_disp_addr, o_mem_we=0, o_eng_gnt=0.
REQ-036 Engine SHALL hold i_eng_req/addr/we/wdata stable until o_eng_gnt; a request is consumed only on a cycle with o_eng_gnt=1.
REQ-037 o_mem_we SHALL never be 1 while i_draw_active=1.

Reset
REQ-038 rst_n low SHALL asynchronously force IDLE, frame counter 0, step-pending 0, o_overrun 0, o_gen_cnt 0, o_eng_start 0, o_busy 0, registered v_sync history 1.
REQ-039 Reset mid-RUN SHALL abandon the generation with no o_gen_cnt increment; the engine is reset by the same rst_n.

Verification
REQ-040 GEN_DIV=4, i_run_en=1, engine done 100 cycles after start -> o_eng_start once every 4 frame events, o_gen_cnt 3 after 12 frames, o_overrun 0.
REQ-041 i_run_en=0, i_step pulse mid-frame -> exactly one o_eng_start at the next frame event, then none for 10 frames.
REQ-042 i_eng_req held with i_eng_we=1 across i_draw_active rising -> o_eng_gnt and o_mem_we drop the same cycle, o_mem_addr=i_disp_addr; grant resumes when i_draw_active falls.
REQ-043 Engine withholds i_eng_done across a frame event -> o_overrun=1; i_clr_ovr pulse -> 0 next cycle.
REQ-044 o_gen_cnt preloaded by 65535 generations, one more done -> o_gen_cnt=0.
REQ-045 rst_n asserted in RUN with i_eng_req=1 -> o_busy=0, o_eng_gnt=0, o_gen_cnt=0 immediately; no o_eng_start until the GEN_DIV-th frame event after release.
